// File: rtl/i2c_bus_sampler.sv
// rtl/i2c_bus_sampler.sv - passive I2C front end: sync, glitch filter, START/STOP detect, byte deserialiser
module i2c_bus_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       scl,
  input  logic       sda,
  output logic       scl_f,
  output logic       sda_f,
  output logic       start_det,
  output logic       rep_start,
  output logic       stop_det,
  output logic       bus_busy,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_ack,
  output logic       first_byte
);

  localparam int CW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);

  typedef enum logic [1:0] {IDLE, BITS, ACK} state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic                   scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;
  logic [CW-1:0]          scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
  logic                   scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       first_q, first_d;
  logic       bus_busy_q, bus_busy_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       byte_ack_q, byte_ack_d;
  logic       first_byte_q, first_byte_d;
  logic       byte_valid_q, byte_valid_d;
  logic       start_det_q, start_det_d;
  logic       rep_start_q, rep_start_d;
  logic       stop_det_q, stop_det_d;

  logic start_cond, stop_cond, scl_rise;

  // Returns {new_filtered_value, new_count}; any sample matching the current value clears the count.
  function automatic logic [CW:0] filt_step(input logic sample, input logic filt,
                                            input logic [CW-1:0] cnt);
    if (sample == filt)                 return {filt, {CW{1'b0}}};
    else if (cnt == CW'(FILT_LEN - 1))  return {~filt, {CW{1'b0}}};
    else                                return {filt, cnt + 1'b1};
  endfunction

  always_comb begin
    scl_sync_d               = {scl_sync_q[SYNC_STAGES-2:0], scl};
    sda_sync_d               = {sda_sync_q[SYNC_STAGES-2:0], sda};
    {scl_filt_d, scl_cnt_d}  = filt_step(scl_sync_q[SYNC_STAGES-1], scl_filt_q, scl_cnt_q);
    {sda_filt_d, sda_cnt_d}  = filt_step(sda_sync_q[SYNC_STAGES-1], sda_filt_q, sda_cnt_q);
    scl_prev_d               = scl_filt_q;
    sda_prev_d               = sda_filt_q;
  end

  // SCL must be high in both cycles, so a simultaneous SCL/SDA change never counts as START/STOP.
  assign start_cond = scl_prev_q & scl_filt_q & sda_prev_q & ~sda_filt_q;
  assign stop_cond  = scl_prev_q & scl_filt_q & ~sda_prev_q & sda_filt_q;
  assign scl_rise   = ~scl_prev_q & scl_filt_q;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    first_d      = first_q;
    bus_busy_d   = bus_busy_q;
    byte_data_d  = byte_data_q;
    byte_ack_d   = byte_ack_q;
    first_byte_d = first_byte_q;
    byte_valid_d = 1'b0;
    start_det_d  = 1'b0;
    rep_start_d  = 1'b0;
    stop_det_d   = 1'b0;

    if (!enable) begin
      state_d    = IDLE;
      bus_busy_d = 1'b0;
      bit_cnt_d  = 3'd0;
    end else if (start_cond) begin
      start_det_d = 1'b1;
      rep_start_d = bus_busy_q;
      bus_busy_d  = 1'b1;
      bit_cnt_d   = 3'd0;
      first_d     = 1'b1;
      state_d     = BITS;
    end else if (stop_cond) begin
      stop_det_d = 1'b1;
      bus_busy_d = 1'b0;
      bit_cnt_d  = 3'd0;
      state_d    = IDLE;
    end else if (scl_rise) begin
      case (state_q)
        BITS: begin
          shreg_d   = {shreg_q[6:0], sda_filt_q};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ACK;
        end
        ACK: begin
          byte_data_d  = shreg_q;
          byte_ack_d   = ~sda_filt_q;
          first_byte_d = first_q;
          byte_valid_d = 1'b1;
          first_d      = 1'b0;
          state_d      = BITS;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q   <= '1;
      sda_sync_q   <= '1;
      scl_filt_q   <= 1'b1;
      sda_filt_q   <= 1'b1;
      scl_cnt_q    <= '0;
      sda_cnt_q    <= '0;
      scl_prev_q   <= 1'b1;
      sda_prev_q   <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      shreg_q      <= 8'd0;
      first_q      <= 1'b0;
      bus_busy_q   <= 1'b0;
      byte_data_q  <= 8'd0;
      byte_ack_q   <= 1'b0;
      first_byte_q <= 1'b0;
      byte_valid_q <= 1'b0;
      start_det_q  <= 1'b0;
      rep_start_q  <= 1'b0;
      stop_det_q   <= 1'b0;
    end else begin
      scl_sync_q   <= scl_sync_d;
      sda_sync_q   <= sda_sync_d;
      scl_filt_q   <= scl_filt_d;
      sda_filt_q   <= sda_filt_d;
      scl_cnt_q    <= scl_cnt_d;
      sda_cnt_q    <= sda_cnt_d;
      scl_prev_q   <= scl_prev_d;
      sda_prev_q   <= sda_prev_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      first_q      <= first_d;
      bus_busy_q   <= bus_busy_d;
      byte_data_q  <= byte_data_d;
      byte_ack_q   <= byte_ack_d;
      first_byte_q <= first_byte_d;
      byte_valid_q <= byte_valid_d;
      start_det_q  <= start_det_d;
      rep_start_q  <= rep_start_d;
      stop_det_q   <= stop_det_d;
    end
  end

  assign scl_f      = scl_filt_q;
  assign sda_f      = sda_filt_q;
  assign start_det  = start_det_q;
  assign rep_start  = rep_start_q;
  assign stop_det   = stop_det_q;
  assign bus_busy   = bus_busy_q;
  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign byte_ack   = byte_ack_q;
  assign first_byte = first_byte_q;

endmodule

// File: tb/tb_i2c_bus_sampler.sv
// tb/tb_i2c_bus_sampler.sv - scoreboard bench for i2c_bus_sampler with a transaction-level bus model
module tb_i2c_bus_sampler;

  localparam int H = 6;
  localparam int EV_START = 1, EV_BYTE = 2, EV_STOP = 3;

  logic clk = 1'b0, rst = 1'b1, enable = 1'b1, scl = 1'b1, sda = 1'b1;
  logic scl_f, sda_f, start_det, rep_start, stop_det, bus_busy;
  logic byte_valid, byte_ack, first_byte;
  logic [7:0] byte_data;

  typedef struct {
    int         kind;
    logic       rep;
    logic [7:0] data;
    logic       ack;
    logic       first;
  } ev_t;

  ev_t exp_q[$];
  int  asserts = 0, fails = 0;
  bit  m_busy = 1'b0, m_first = 1'b0;

  i2c_bus_sampler #(.SYNC_STAGES(2), .FILT_LEN(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .scl(scl), .sda(sda),
    .scl_f(scl_f), .sda_f(sda_f), .start_det(start_det), .rep_start(rep_start),
    .stop_det(stop_det), .bus_busy(bus_busy), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ack(byte_ack), .first_byte(first_byte)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input logic rep, input logic [7:0] data,
                      input logic ack, input logic first);
    ev_t e;
    e.kind = kind; e.rep = rep; e.data = data; e.ack = ack; e.first = first;
    if (enable) exp_q.push_back(e);
  endtask

  task automatic take(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      asserts++; fails++;
      $display("FAIL unexpected_event: got kind %0d, expected none at %0t", kind, $time);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == e.kind && kind == EV_START) check("rep_start", rep_start, e.rep);
      if (kind == e.kind && kind == EV_BYTE) begin
        check("byte_data", byte_data, e.data);
        check("byte_ack", byte_ack, e.ack);
        check("first_byte", first_byte, e.first);
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("rep_start_alone", rep_start & ~start_det, 0);
      if (start_det)  take(EV_START);
      if (byte_valid) take(EV_BYTE);
      if (stop_det)   take(EV_STOP);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    if (!scl) begin
      sda = 1'b1; wait_clk(H);
      scl = 1'b1; wait_clk(H);
    end
    push(EV_START, m_busy, 8'd0, 1'b0, 1'b0);
    if (enable) begin m_busy = 1'b1; m_first = 1'b1; end
    sda = 1'b0; wait_clk(H);
    scl = 1'b0; wait_clk(H);
  endtask

  task automatic send_bit(input logic b);
    sda = b;    wait_clk(H);
    scl = 1'b1; wait_clk(H);
    scl = 1'b0; wait_clk(H);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    if (m_busy) push(EV_BYTE, 1'b0, d, ack, m_first);
    m_first = 1'b0;
    send_bit(~ack);
  endtask

  task automatic bus_stop();
    sda = 1'b0; wait_clk(H);
    scl = 1'b1; wait_clk(H);
    push(EV_STOP, 1'b0, 8'd0, 1'b0, 1'b0);
    m_busy = 1'b0;
    sda = 1'b1; wait_clk(H);
  endtask

  initial begin
    logic [7:0] d;
    int nb;
    // Reset with idle lines, then 100 idle cycles.
    wait_clk(3);
    check("rst_scl_f", scl_f, 1); check("rst_sda_f", sda_f, 1);
    check("rst_byte_data", byte_data, 0); check("rst_bus_busy", bus_busy, 0);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      wait_clk(1);
      check("idle_lines", {scl_f, sda_f}, 2'b11);
      check("idle_busy", bus_busy, 0);
    end

    // Single address byte with ACK.
    bus_start(); send_byte(8'hA4, 1'b1); bus_stop();
    check("busy_after_stop", bus_busy, 0);

    // Two bytes, repeated START, one more byte.
    bus_start(); send_byte(8'h51, 1'b1); send_byte(8'h3C, 1'b0);
    bus_start(); check("busy_mid", bus_busy, 1);
    send_byte(8'hFF, 1'b1); bus_stop();

    // SDA glitches while SCL high: 2 clk filtered out, 3 clk passes as START then STOP.
    wait_clk(H);
    sda = 1'b0; wait_clk(2); sda = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_clk(1); check("glitch_sda_f", sda_f, 1);
    end
    push(EV_START, 1'b0, 8'd0, 1'b0, 1'b0);
    sda = 1'b0; wait_clk(3);
    push(EV_STOP, 1'b0, 8'd0, 1'b0, 1'b0);
    sda = 1'b1; wait_clk(2 * H);

    // STOP after 5 data bits, then a zero byte.
    bus_start();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    bus_stop();
    bus_start(); send_byte(8'h00, 1'b1); bus_stop();

    // Asynchronous reset after 4 bits; remainder of the byte must be ignored.
    bus_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", bus_busy, 0); check("mid_rst_scl_f", scl_f, 1);
    check("mid_rst_sda_f", sda_f, 1); check("mid_rst_byte_data", byte_data, 0);
    check("mid_rst_pulses", {start_det, rep_start, stop_det, byte_valid}, 0);
    m_busy = 1'b0; m_first = 1'b0;
    wait_clk(2); rst = 1'b0;
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    bus_stop();

    // Disabled sampler: whole transaction produces nothing.
    enable = 1'b0;
    bus_start(); check("dis_busy", bus_busy, 0);
    send_byte(8'h5A, 1'b1); bus_stop();
    wait_clk(H); enable = 1'b1; wait_clk(H);

    // Randomised transactions with repeated STARTs and aborted bytes.
    for (int t = 0; t < 20; t++) begin
      bus_start();
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        d = 8'($urandom);
        send_byte(d, 1'($urandom));
        if ($urandom_range(0, 3) == 0) bus_start();
      end
      if ($urandom_range(0, 4) == 0)
        for (int i = 0; i < $urandom_range(1, 7); i++) send_bit(1'($urandom));
      bus_stop();
      wait_clk($urandom_range(H, 3 * H));
    end

    wait_clk(20);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
